// File: rtl/acc_trig_pkg.sv
// Shared types and record-layout helpers for the AOM trigger/encoder logger.
// Record layout, MSB to LSB: zero pad, timestamp, channel id, encoder W, encoder X.
package acc_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        STOP  = 2'd2
    } trig_state_e;

    // Widest record the packing helper can build; DATA_W must not exceed it.
    localparam int REC_MAX_W = 256;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
    localparam int REC_X_LSB = 0;

    function automatic int ch_idx_width(input int ch_num);
        return (ch_num <= 2) ? 1 : $clog2(ch_num);
    endfunction

    function automatic int rec_w_lsb(input int enc_w);
        return REC_X_LSB + enc_w;
    endfunction

    function automatic int rec_ch_lsb(input int enc_w);
        return REC_X_LSB + 2 * enc_w;
    endfunction

    function automatic int rec_ts_lsb(input int enc_w, input int ch_w);
        return REC_X_LSB + 2 * enc_w + ch_w;
    endfunction

    // Fields arrive zero-extended to REC_MAX_W; the caller truncates to DATA_W.
    function automatic logic [REC_MAX_W-1:0] pack_record(
        input logic [REC_MAX_W-1:0] ts,
        input logic [REC_MAX_W-1:0] ch,
        input logic [REC_MAX_W-1:0] w,
        input logic [REC_MAX_W-1:0] x,
        input int                   enc_w,
        input int                   ch_w
    );
        return (ts << rec_ts_lsb(enc_w, ch_w)) |
               (ch << rec_ch_lsb(enc_w)) |
               (w  << rec_w_lsb(enc_w)) |
               (x  << REC_X_LSB);
    endfunction

endpackage

// File: rtl/acc_trig_sync_fifo.sv
// Generic single-clock FIFO: standard (registered) read, synchronous clear,
// occupancy output and an optional registered almost-full flag.
module acc_trig_sync_fifo #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 64,
    parameter int AFULL_TH = DEPTH - 8,
    parameter bit AFULL_EN = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_vld,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   afull
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_vld_reg;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // A clear overrides any access issued in the same cycle.
    assign wr_ok   = wr_en & ~full & ~clr;
    assign rd_ok   = rd_en & ~empty & ~clr;
    assign rd_data = rd_data_reg;
    assign rd_vld  = rd_vld_reg;
    assign level   = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (wr_ok && !rd_ok) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
            rd_vld_reg  <= 1'b0;
        end else begin
            count_reg  <= count_next;
            rd_vld_reg <= rd_ok;
            if (clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (rd_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
            if (rd_ok) begin
                rd_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    generate
        if (AFULL_EN) begin : g_afull
            logic afull_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    afull_reg <= 1'b0;
                end else begin
                    afull_reg <= (count_next >= (AW+1)'(AFULL_TH));
                end
            end
            assign afull = afull_reg;
        end else begin : g_no_afull
            assign afull = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/acc_trigger_logger.sv
// Multi-channel AOM trigger logger: timestamps each AOM rising edge with encoder W/X
// into a FIFO. Define ACC_TRIG_LEVEL_EN to expose FIFO occupancy and almost-full.
module acc_trigger_logger
    import acc_trig_pkg::*;
#(
    parameter real TCQ        = 0.1,
    parameter int  CH_NUM     = 2,
    parameter int  ENC_W      = 18,
    parameter int  TS_W       = 26,
    parameter int  FIFO_DEPTH = 1024,
    parameter int  DATA_W     = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      laser_start_i,
    input  logic [CH_NUM-1:0]         aom_ctrl_flag_i,
    input  logic [ENC_W-1:0]          encode_w_i,
    input  logic [ENC_W-1:0]          encode_x_i,
    output logic                      trig_fifo_ready_o,
    input  logic                      trig_fifo_rd_i,
    output logic [DATA_W-1:0]         trig_fifo_data_o,
    output logic                      trig_fifo_vld_o,
    output logic [31:0]               acc_trigger_num_o,
    output logic [15:0]               acc_drop_num_o,
    output logic                      overflow_o
`ifdef ACC_TRIG_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] trig_fifo_level_o,
    output logic                        trig_fifo_afull_o
`endif
);
    localparam int CH_IDX_W = ch_idx_width(CH_NUM);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
`ifdef ACC_TRIG_LEVEL_EN
    localparam bit LEVEL_EN = 1'b1;
`else
    localparam bit LEVEL_EN = 1'b0;
`endif

    generate
        if (TS_W + CH_IDX_W + 2 * ENC_W > DATA_W) begin : g_bad_data_w
            $error("acc_trigger_logger: record fields do not fit in DATA_W");
        end
        if (DATA_W > REC_MAX_W || TCQ < 0.0) begin : g_bad_cfg
            $error("acc_trigger_logger: DATA_W too wide or negative TCQ");
        end
        if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
            $error("acc_trigger_logger: CH_NUM must be 1..8");
        end
        if (FIFO_DEPTH < 16 || FIFO_DEPTH > 4096 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("acc_trigger_logger: FIFO_DEPTH must be a power of two in 16..4096");
        end
    endgenerate

    trig_state_e         state_reg;
    logic                laser_q_reg;
    logic [CH_NUM-1:0]   aom_q_reg;
    logic [TS_W-1:0]     ts_reg;
    logic [CH_NUM-1:0]   pending_reg;
    logic [31:0]         acc_num_reg;
    logic [15:0]         drop_num_reg;
    logic                overflow_reg;

    logic                laser_rise;
    logic                laser_fall;
    logic [CH_NUM-1:0]   aom_rise;
    logic                session_clr;
    logic [CH_NUM:0]     lower_pend;
    logic [CH_NUM-1:0]   grant_mask;
    logic                grant_vld;
    logic [CH_IDX_W-1:0] grant_idx;
    logic [CH_NUM-1:0]   retrig;
    logic                fifo_full;
    logic                fifo_empty;
    logic                full_drop;
    logic                fifo_wr;
    logic [DATA_W-1:0]   fifo_wr_data;
    logic [4:0]          drop_inc;
    logic [16:0]         drop_sum;
    logic [15:0]         drop_next;
    logic [LVL_W-1:0]    fifo_level;
    logic                fifo_afull;

    assign laser_rise  = laser_start_i & ~laser_q_reg;
    assign laser_fall  = ~laser_start_i & laser_q_reg;
    assign aom_rise    = aom_ctrl_flag_i & ~aom_q_reg;
    assign session_clr = laser_rise & (state_reg != ARMED);

    // Fixed priority: a channel wins only when no lower-index channel is pending.
    genvar gi;
    assign lower_pend[0] = 1'b0;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_grant
            assign lower_pend[gi+1] = lower_pend[gi] | pending_reg[gi];
            assign grant_mask[gi]   = pending_reg[gi] & ~lower_pend[gi];
        end
    endgenerate
    assign grant_vld = lower_pend[CH_NUM];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant_mask[i]) begin
                grant_idx = CH_IDX_W'(i);
            end
        end
    end

    // The channel being granted this cycle still counts as pending for a new edge.
    assign retrig    = aom_rise & pending_reg;
    assign fifo_wr   = (state_reg == ARMED) & grant_vld & ~fifo_full;
    assign full_drop = (state_reg == ARMED) & grant_vld & fifo_full;

    assign fifo_wr_data = DATA_W'(pack_record(REC_MAX_W'(ts_reg), REC_MAX_W'(grant_idx),
                                              REC_MAX_W'(encode_w_i), REC_MAX_W'(encode_x_i),
                                              ENC_W, CH_IDX_W));

    always_comb begin
        drop_inc = '0;
        case (state_reg)
            ARMED:   drop_inc = 5'($countones(retrig)) + {4'd0, full_drop};
            STOP:    drop_inc = 5'($countones(pending_reg));
            default: drop_inc = '0;
        endcase
    end

    assign drop_sum  = {1'b0, drop_num_reg} + 17'(drop_inc);
    assign drop_next = (drop_sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : drop_sum[15:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            laser_q_reg  <= 1'b0;
            aom_q_reg    <= '0;
            ts_reg       <= '0;
            pending_reg  <= '0;
            acc_num_reg  <= '0;
            drop_num_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            laser_q_reg <= laser_start_i;
            aom_q_reg   <= aom_ctrl_flag_i;
            if (session_clr) begin
                state_reg    <= ARMED;
                ts_reg       <= '0;
                pending_reg  <= '0;
                acc_num_reg  <= '0;
                drop_num_reg <= '0;
                overflow_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ARMED: begin
                        ts_reg       <= ts_reg + TS_W'(1);
                        pending_reg  <= (pending_reg & ~grant_mask) | (aom_rise & ~pending_reg);
                        drop_num_reg <= drop_next;
                        if (fifo_wr) begin
                            acc_num_reg <= acc_num_reg + 32'd1;
                        end
                        if (drop_inc != '0) begin
                            overflow_reg <= 1'b1;
                        end
                        if (laser_fall) begin
                            state_reg <= STOP;
                        end
                    end
                    STOP: begin
                        // Grants left over from the session are discarded as drops.
                        pending_reg  <= '0;
                        drop_num_reg <= drop_next;
                        if (drop_inc != '0) begin
                            overflow_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    acc_trig_sync_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .WIDTH    (DATA_W),
        .AFULL_TH (FIFO_DEPTH - 8),
        .AFULL_EN (LEVEL_EN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (session_clr),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_data),
        .rd_en   (trig_fifo_rd_i),
        .rd_data (trig_fifo_data_o),
        .rd_vld  (trig_fifo_vld_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .afull   (fifo_afull)
    );

    assign trig_fifo_ready_o = ~fifo_empty;
    assign acc_trigger_num_o = acc_num_reg;
    assign acc_drop_num_o    = drop_num_reg;
    assign overflow_o        = overflow_reg;

`ifdef ACC_TRIG_LEVEL_EN
    assign trig_fifo_level_o = fifo_level;
    assign trig_fifo_afull_o = fifo_afull;
`else
    logic [LVL_W-1:0] unused_level;
    logic             unused_afull;
    assign unused_level = fifo_level;
    assign unused_afull = fifo_afull;
`endif

endmodule
